// File: rtl/mult_datapath_taint_track_word_if.sv
// Control/data bus between the multiplier FSM (master) and its taint-tracking datapath (slave).
// Optional MULT_DP_SHCOUNT_EN adds shift_count and product_valid.
interface mult_datapath_taint_track_word_if #(
    parameter int unsigned WIDTH = 4
);
    localparam int unsigned CW = $clog2(WIDTH + 2);

    logic [WIDTH-1:0]   multiplicand;
    logic               multiplicand_t;
    logic [WIDTH-1:0]   multiplier;
    logic               multiplier_t;
    logic               mdld;
    logic               mdld_t;
    logic               mrld;
    logic               mrld_t;
    logic               rsclear;
    logic               rsclear_t;
    logic               rsload;
    logic               rsload_t;
    logic               rsshr;
    logic               rsshr_t;
    logic [WIDTH-1:0]   multiplierReg;
    logic               multiplierReg_t;
    logic [2*WIDTH-1:0] product;
    logic               product_t;

`ifdef MULT_DP_SHCOUNT_EN
    logic [CW-1:0]      shift_count;
    logic               product_valid;

    modport master (
        output multiplicand, multiplicand_t, multiplier, multiplier_t,
               mdld, mdld_t, mrld, mrld_t, rsclear, rsclear_t,
               rsload, rsload_t, rsshr, rsshr_t,
        input  multiplierReg, multiplierReg_t, product, product_t,
               shift_count, product_valid
    );

    modport slave (
        input  multiplicand, multiplicand_t, multiplier, multiplier_t,
               mdld, mdld_t, mrld, mrld_t, rsclear, rsclear_t,
               rsload, rsload_t, rsshr, rsshr_t,
        output multiplierReg, multiplierReg_t, product, product_t,
               shift_count, product_valid
    );
`else
    modport master (
        output multiplicand, multiplicand_t, multiplier, multiplier_t,
               mdld, mdld_t, mrld, mrld_t, rsclear, rsclear_t,
               rsload, rsload_t, rsshr, rsshr_t,
        input  multiplierReg, multiplierReg_t, product, product_t
    );

    modport slave (
        input  multiplicand, multiplicand_t, multiplier, multiplier_t,
               mdld, mdld_t, mrld, mrld_t, rsclear, rsclear_t,
               rsload, rsload_t, rsshr, rsshr_t,
        output multiplierReg, multiplierReg_t, product, product_t
    );
`endif
endinterface

// File: rtl/mult_datapath_taint_track_word.sv
// Shift-add multiplier datapath with one sticky taint bit per architectural register.
// Optional MULT_DP_SHCOUNT_EN adds a saturating shift counter and product_valid flag.
module mult_datapath_taint_track_word #(
    parameter int unsigned WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    mult_datapath_taint_track_word_if.slave bus
);
    localparam int unsigned RW = 2 * WIDTH + 1;

    logic [WIDTH-1:0] md;
    logic [WIDTH-1:0] mr;
    logic [RW-1:0]    rs;
    logic             md_t;
    logic             mr_t;
    logic             rs_t;

    logic [WIDTH-1:0] md_next;
    logic [WIDTH-1:0] mr_next;
    logic [RW-1:0]    rs_next;
    logic [WIDTH:0]   sum;
    logic             md_t_next;
    logic             mr_t_next;
    logic             rs_t_next;

    // Next-state for operands, result register and their taints
    always_comb begin
        md_next   = md;
        mr_next   = mr;
        rs_next   = rs;
        sum       = rs[RW-1:WIDTH];
        md_t_next = md_t | bus.mdld_t;
        mr_t_next = mr_t | bus.mrld_t;

        if (bus.mdld) begin
            md_next   = bus.multiplicand;
            md_t_next = bus.multiplicand_t | bus.mdld_t;
        end
        if (bus.mrld) begin
            mr_next   = bus.multiplier;
            mr_t_next = bus.multiplier_t | bus.mrld_t;
        end

        // Add uses the pre-load md; carry lands in the top bit and is absorbed by the shift
        if (bus.rsclear) begin
            rs_next = '0;
        end else begin
            if (bus.rsload) begin
                sum     = rs[RW-1:WIDTH] + (WIDTH+1)'(md);
                rs_next = {sum, rs[WIDTH-1:0]};
            end
            if (bus.rsshr) begin
                rs_next = {1'b0, rs_next[RW-1:1]};
            end
        end

        // Strobe taints flow even when the strobe itself is low
        if (bus.rsclear) begin
            rs_t_next = bus.rsclear_t | bus.rsload_t | bus.rsshr_t;
        end else begin
            rs_t_next = rs_t | (bus.rsload & md_t) | bus.rsload_t
                      | bus.rsshr_t | bus.rsclear_t;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            md   <= '0;
            mr   <= '0;
            rs   <= '0;
            md_t <= 1'b0;
            mr_t <= 1'b0;
            rs_t <= 1'b0;
        end else begin
            md   <= md_next;
            mr   <= mr_next;
            rs   <= rs_next;
            md_t <= md_t_next;
            mr_t <= mr_t_next;
            rs_t <= rs_t_next;
        end
    end

    assign bus.multiplierReg   = mr;
    assign bus.multiplierReg_t = mr_t;
    assign bus.product         = rs[2*WIDTH-1:0];
    assign bus.product_t       = rs_t;

`ifdef MULT_DP_SHCOUNT_EN
    localparam int unsigned CW = $clog2(WIDTH + 2);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          valid;

    // Saturating count of right shifts since the last clear
    always_comb begin
        cnt_next = cnt;
        if (bus.rsclear) begin
            cnt_next = '0;
        end else if (bus.rsshr && (cnt != CW'(WIDTH + 1))) begin
            cnt_next = cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            valid <= 1'b0;
        end else begin
            cnt   <= cnt_next;
            valid <= (cnt_next == CW'(WIDTH));
        end
    end

    assign bus.shift_count   = cnt;
    assign bus.product_valid = valid;
`endif

endmodule

// File: tb/tb_mult_datapath_taint_track_word.sv
// Directed self-checking bench for mult_datapath_taint_track_word (WIDTH=4).
// Counter checks are compiled in when MULT_DP_SHCOUNT_EN is defined.
module tb_mult_datapath_taint_track_word;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    mult_datapath_taint_track_word_if #(.WIDTH(4)) bus ();

    mult_datapath_taint_track_word #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.multiplicand_t = 1'b0;
        bus.multiplier_t   = 1'b0;
        bus.mdld   = 1'b0; bus.mdld_t    = 1'b0;
        bus.mrld   = 1'b0; bus.mrld_t    = 1'b0;
        bus.rsclear = 1'b0; bus.rsclear_t = 1'b0;
        bus.rsload = 1'b0; bus.rsload_t  = 1'b0;
        bus.rsshr  = 1'b0; bus.rsshr_t   = 1'b0;
    endtask

    // Load both operands and clear the result register in one cycle
    task automatic load(input logic [3:0] a, input logic at, input logic [3:0] b, input logic bt);
        idle();
        bus.multiplicand   = a;
        bus.multiplicand_t = at;
        bus.multiplier     = b;
        bus.multiplier_t   = bt;
        bus.mdld = 1'b1; bus.mrld = 1'b1; bus.rsclear = 1'b1;
        tick();
        idle();
    endtask

    task automatic run_mult(input logic [3:0] b, input bit combined);
        for (int i = 0; i < 4; i++) begin
            if (combined) begin
                bus.rsload = b[i];
                bus.rsshr  = 1'b1;
                tick();
            end else begin
                if (b[i]) begin
                    bus.rsload = 1'b1;
                    tick();
                    bus.rsload = 1'b0;
                end
                bus.rsshr = 1'b1;
                tick();
            end
            bus.rsload = 1'b0;
            bus.rsshr  = 1'b0;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // Reset with everything asserted
        bus.multiplicand = 4'hF; bus.multiplier = 4'hF;
        bus.multiplicand_t = 1'b1; bus.multiplier_t = 1'b1;
        bus.mdld = 1'b1; bus.mdld_t = 1'b1; bus.mrld = 1'b1; bus.mrld_t = 1'b1;
        bus.rsclear = 1'b1; bus.rsclear_t = 1'b1; bus.rsload = 1'b1; bus.rsload_t = 1'b1;
        bus.rsshr = 1'b1; bus.rsshr_t = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        check("rst_product",   32'(bus.product), 32'd0);
        check("rst_mr",        32'(bus.multiplierReg), 32'd0);
        check("rst_product_t", 32'(bus.product_t), 32'd0);
        check("rst_mr_t",      32'(bus.multiplierReg_t), 32'd0);
`ifdef MULT_DP_SHCOUNT_EN
        check("rst_count", 32'(bus.shift_count), 32'd0);
        check("rst_valid", 32'(bus.product_valid), 32'd0);
`endif
        idle();
        rst = 1'b0;
        tick();

        // 13 x 11, separate add and shift cycles
        load(4'd13, 1'b0, 4'd11, 1'b0);
        check("load_mr",      32'(bus.multiplierReg), 32'd11);
        check("load_product", 32'(bus.product), 32'd0);
        bus.rsload = 1'b1;
        tick();
        bus.rsload = 1'b0;
        check("first_add", 32'(bus.product), 32'hD0);
        bus.rsshr = 1'b1;
        tick();
        bus.rsshr = 1'b0;
        check("first_shift", 32'(bus.product), 32'h68);
        load(4'd13, 1'b0, 4'd11, 1'b0);
        run_mult(4'd11, 1'b0);
        check("sep_13x11",   32'(bus.product), 32'd143);
        check("sep_13x11_t", 32'(bus.product_t), 32'd0);
`ifdef MULT_DP_SHCOUNT_EN
        check("count_4", 32'(bus.shift_count), 32'd4);
        check("valid_4", 32'(bus.product_valid), 32'd1);
        bus.rsshr = 1'b1;
        tick();
        check("count_5", 32'(bus.shift_count), 32'd5);
        check("valid_5", 32'(bus.product_valid), 32'd0);
        tick();
        bus.rsshr = 1'b0;
        check("count_sat", 32'(bus.shift_count), 32'd5);
        check("valid_sat", 32'(bus.product_valid), 32'd0);
`endif

        // 13 x 11, add and shift together
        load(4'd13, 1'b0, 4'd11, 1'b0);
        run_mult(4'd11, 1'b1);
        check("comb_13x11", 32'(bus.product), 32'd143);

        // 15 x 15, carry into the top bit
        load(4'd15, 1'b0, 4'd15, 1'b0);
        bus.rsload = 1'b1; tick(); bus.rsload = 1'b0;
        bus.rsshr  = 1'b1; tick(); bus.rsshr  = 1'b0;
        bus.rsload = 1'b1; tick(); bus.rsload = 1'b0;
        check("carry_add", 32'(bus.product), 32'h68);
        bus.rsshr  = 1'b1; tick(); bus.rsshr  = 1'b0;
        check("carry_shift", 32'(bus.product), 32'hB4);
        load(4'd15, 1'b0, 4'd15, 1'b0);
        run_mult(4'd15, 1'b0);
        check("sep_15x15", 32'(bus.product), 32'd225);
        load(4'd15, 1'b0, 4'd15, 1'b0);
        run_mult(4'd15, 1'b1);
        check("comb_15x15", 32'(bus.product), 32'd225);

        // Simultaneous mdld and rsload: add sees the old md
        load(4'd13, 1'b0, 4'd0, 1'b0);
        bus.multiplicand = 4'd2; bus.mdld = 1'b1; bus.rsload = 1'b1;
        tick();
        idle();
        check("old_md_add", 32'(bus.product), 32'hD0);
        bus.rsload = 1'b1;
        tick();
        idle();
        check("new_md_add", 32'(bus.product), 32'hF0);

        // Data taint: tainted md never added
        load(4'd5, 1'b1, 4'd0, 1'b0);
        run_mult(4'd0, 1'b0);
        check("md_t_noadd",   32'(bus.product_t), 32'd0);
        check("md_t_noadd_p", 32'(bus.product), 32'd0);
        load(4'd5, 1'b1, 4'd1, 1'b0);
        bus.rsload = 1'b1; tick(); bus.rsload = 1'b0;
        check("md_t_add",   32'(bus.product_t), 32'd1);
        check("md_t_add_p", 32'(bus.product), 32'h50);
        bus.rsshr = 1'b1; tick(); tick(); tick(); tick(); bus.rsshr = 1'b0;
        check("md_t_final",   32'(bus.product), 32'd5);
        check("md_t_sticky",  32'(bus.product_t), 32'd1);
        check("md_t_mr_clean", 32'(bus.multiplierReg_t), 32'd0);

        // Multiplier taint: data taint, clean reload, implicit via mrld_t
        load(4'd1, 1'b0, 4'd7, 1'b1);
        check("mr_t_data", 32'(bus.multiplierReg_t), 32'd1);
        load(4'd1, 1'b0, 4'd7, 1'b0);
        check("mr_t_clean", 32'(bus.multiplierReg_t), 32'd0);
        bus.mrld_t = 1'b1; tick(); idle();
        check("mr_t_implicit", 32'(bus.multiplierReg_t), 32'd1);
        check("mr_hold",       32'(bus.multiplierReg), 32'd7);

        // Implicit taint through an idle shift strobe
        load(4'd3, 1'b0, 4'd0, 1'b0);
        bus.rsload = 1'b1; tick(); idle();
        check("impl_clean", 32'(bus.product_t), 32'd0);
        bus.rsshr_t = 1'b1; tick(); idle();
        check("impl_taint", 32'(bus.product_t), 32'd1);
        check("impl_noshift", 32'(bus.product), 32'h30);
        tick();
        check("impl_sticky", 32'(bus.product_t), 32'd1);
        bus.rsclear = 1'b1; tick(); idle();
        check("impl_cleared",   32'(bus.product_t), 32'd0);
        check("impl_cleared_p", 32'(bus.product), 32'd0);

        // Mid-run reset overrides strobes
        load(4'd9, 1'b1, 4'd9, 1'b1);
        bus.rsload = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        check("rst2_product_t", 32'(bus.product_t), 32'd0);
        check("rst2_mr",        32'(bus.multiplierReg), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
